mem_stage: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline register (MEM_* signals) and drives the data-memory request/response handshake.
- Aligns store data and byte masks, and extracts/extends load data.
- Registers results into the MEM/WB pipeline register (WB_* signals).
- Asserts a stall upstream while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/mem_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 encodings, writeback
// select encodings, access sizes and the handshake FSM state type.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] WB_SEL_PC4  = 2'b00;
   localparam logic [1:0] WB_SEL_ALU  = 2'b01;
   localparam logic [1:0] WB_SEL_LOAD = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // The low two funct3 bits give the access size for both loads and stores.
   function automatic logic isAligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         SZ_BYTE: isAligned = 1'b1;
         SZ_HALF: isAligned = ~off[0];
         default: isAligned = (off == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte enables,
// misalignment detection, and load byte/halfword extraction with extension.
module lsu_align
   import mem_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] storeData_i,
   input  logic [31:0] loadWord_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  bmask_o,
   output logic        misalign_o,
   output logic [31:0] loadData_o
);

   logic [31:0] shiftedWord;

   always_comb begin
      wdata_o = storeData_i;
      bmask_o = 4'b1111;
      case (funct3_i)
         F3_SB: begin
            wdata_o = {4{storeData_i[7:0]}};
            bmask_o = 4'b0001 << off_i;
         end
         F3_SH: begin
            wdata_o = {2{storeData_i[15:0]}};
            bmask_o = 4'b0011 << off_i;
         end
         F3_SW: begin
            wdata_o = storeData_i;
            bmask_o = 4'b1111;
         end
         default: ;
      endcase
   end

   assign misalign_o  = ~isAligned(funct3_i, off_i);
   assign shiftedWord = loadWord_i >> {off_i, 3'b000};

   always_comb begin
      loadData_o = 32'h0;
      case (funct3_i)
         F3_LB:   loadData_o = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
         F3_LH:   loadData_o = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
         F3_LW:   loadData_o = shiftedWord;
         F3_LBU:  loadData_o = {24'h0, shiftedWord[7:0]};
         F3_LHU:  loadData_o = {16'h0, shiftedWord[15:0]};
         default: loadData_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: drives the data-memory req/ready/rvalid handshake,
// stalls upstream while an access is outstanding, and loads the MEM/WB register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] MEM_alu_data,
   input  logic [31:0] MEM_rs2_data,
   input  logic [31:0] MEM_pc,
   input  logic [31:0] MEM_inst,
   input  logic [4:0]  MEM_rd_addr,
   input  logic [2:0]  MEM_funct3,
   input  logic [1:0]  MEM_wb_sel,
   input  logic        MEM_rd_wren,
   input  logic        MEM_mem_wren,
   input  logic        MEM_mem_rden,
   input  logic        MEM_insn_vld,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_bmask,
   input  logic        i_dmem_ready,
   input  logic        i_dmem_rvalid,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_mem_stall,
   output logic        o_misalign,
   output logic        o_dmem_err,
   output logic [31:0] WB_alu_data,
   output logic [31:0] WB_ld_data,
   output logic [31:0] WB_pc_four,
   output logic [31:0] WB_inst,
   output logic [4:0]  WB_rd_addr,
   output logic [1:0]  WB_wb_sel,
   output logic        WB_rd_wren,
   output logic        WB_insn_vld
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0] wbAluData_q, wbLdData_q, wbPcFour_q, wbInst_q;
   logic [4:0]  wbRdAddr_q;
   logic [1:0]  wbWbSel_q;
   logic        wbRdWren_q, wbInsnVld_q;

   logic        access, misalign, timeout;
   logic        req, stall, misPulse, errPulse, loadDone;
   logic [31:0] loadData;

   lsu_align uAlign (
      .off_i       (MEM_alu_data[1:0]),
      .funct3_i    (MEM_funct3),
      .storeData_i (MEM_rs2_data),
      .loadWord_i  (i_dmem_rdata),
      .wdata_o     (o_dmem_wdata),
      .bmask_o     (o_dmem_bmask),
      .misalign_o  (misalign),
      .loadData_o  (loadData)
   );

   assign access  = MEM_insn_vld & (MEM_mem_rden | MEM_mem_wren);
   assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_W'(WAIT_LIMIT));

   // Store wins when both rden and wren are set, so wren alone decides direction.
   always_comb begin
      state_d  = state_q;
      req      = 1'b0;
      stall    = 1'b0;
      misPulse = 1'b0;
      errPulse = 1'b0;
      loadDone = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               if (misalign) begin
                  misPulse = 1'b1;
               end else begin
                  req = 1'b1;
                  if (i_dmem_ready) begin
                     if (!MEM_mem_wren) begin
                        state_d = ST_RESP;
                        stall   = 1'b1;
                     end
                  end else begin
                     state_d = ST_REQ;
                     stall   = 1'b1;
                  end
               end
            end
         end
         ST_REQ: begin
            if (timeout) begin
               errPulse = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               req = 1'b1;
               if (i_dmem_ready) begin
                  if (MEM_mem_wren) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_RESP;
                     stall   = 1'b1;
                  end
               end else begin
                  stall = 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (timeout) begin
               errPulse = 1'b1;
               state_d  = ST_IDLE;
            end else if (i_dmem_rvalid) begin
               loadDone = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Watchdog restarts on every state change so REQ and RESP each get a full budget.
   assign cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst || stall) begin
         wbAluData_q <= 32'h0;
         wbLdData_q  <= 32'h0;
         wbPcFour_q  <= 32'h0;
         wbInst_q    <= 32'h0;
         wbRdAddr_q  <= 5'h0;
         wbWbSel_q   <= 2'h0;
         wbRdWren_q  <= 1'b0;
         wbInsnVld_q <= 1'b0;
      end else begin
         wbAluData_q <= MEM_alu_data;
         wbLdData_q  <= loadDone ? loadData : 32'h0;
         wbPcFour_q  <= MEM_pc + 32'd4;
         wbInst_q    <= MEM_inst;
         wbRdAddr_q  <= MEM_rd_addr;
         wbWbSel_q   <= MEM_wb_sel;
         wbRdWren_q  <= MEM_rd_wren && (MEM_rd_addr != 5'd0) && !misPulse && !errPulse;
         wbInsnVld_q <= MEM_insn_vld;
      end
   end

   assign o_dmem_req  = req & i_rst;
   assign o_dmem_we   = req & i_rst & MEM_mem_wren;
   assign o_dmem_addr = {MEM_alu_data[31:2], 2'b00};
   assign o_mem_stall = stall & i_rst;
   assign o_misalign  = misPulse & i_rst;
   assign o_dmem_err  = errPulse & i_rst;

   assign WB_alu_data = wbAluData_q;
   assign WB_ld_data  = wbLdData_q;
   assign WB_pc_four  = wbPcFour_q;
   assign WB_inst     = wbInst_q;
   assign WB_rd_addr  = wbRdAddr_q;
   assign WB_wb_sel   = wbWbSel_q;
   assign WB_rd_wren  = wbRdWren_q;
   assign WB_insn_vld = wbInsnVld_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: single-cycle vector table plus multi-cycle load,
// watchdog and reset sequences, with expected MEM/WB contents queued per instruction.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] memAlu, memRs2, memPc, memInst;
   logic [4:0]  memRd;
   logic [2:0]  memF3;
   logic [1:0]  memWbSel;
   logic        memRdWren, memWren, memRden, memVld;
   logic        dmemReq, dmemWe;
   logic [31:0] dmemAddr, dmemWdata;
   logic [3:0]  dmemMask;
   logic        dmemReady, dmemRvalid;
   logic [31:0] dmemRdata;
   logic        memStall, misalignOut, dmemErr;
   logic [31:0] wbAlu, wbLd, wbPc4, wbInst;
   logic [4:0]  wbRd;
   logic [1:0]  wbSel;
   logic        wbRdWren, wbVld;

   always #5 clk = ~clk;

   mem_stage #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst(rstN),
      .MEM_alu_data(memAlu), .MEM_rs2_data(memRs2), .MEM_pc(memPc), .MEM_inst(memInst),
      .MEM_rd_addr(memRd), .MEM_funct3(memF3), .MEM_wb_sel(memWbSel),
      .MEM_rd_wren(memRdWren), .MEM_mem_wren(memWren), .MEM_mem_rden(memRden),
      .MEM_insn_vld(memVld),
      .o_dmem_req(dmemReq), .o_dmem_we(dmemWe), .o_dmem_addr(dmemAddr),
      .o_dmem_wdata(dmemWdata), .o_dmem_bmask(dmemMask),
      .i_dmem_ready(dmemReady), .i_dmem_rvalid(dmemRvalid), .i_dmem_rdata(dmemRdata),
      .o_mem_stall(memStall), .o_misalign(misalignOut), .o_dmem_err(dmemErr),
      .WB_alu_data(wbAlu), .WB_ld_data(wbLd), .WB_pc_four(wbPc4), .WB_inst(wbInst),
      .WB_rd_addr(wbRd), .WB_wb_sel(wbSel), .WB_rd_wren(wbRdWren), .WB_insn_vld(wbVld)
   );

   typedef struct {
      logic [31:0] alu, ld, pc4, inst;
      logic [4:0]  rd;
      logic [1:0]  wbsel;
      logic        rdwren, vld;
   } wb_t;

   typedef struct {
      logic [31:0] alu, rs2, pc, inst;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  wbsel;
      logic        rdwren, wren, rden, vld, ready;
      logic        expReq, expWe;
      logic [31:0] expAddr, expWdata;
      logic [3:0]  expMask;
      logic        expMis;
      wb_t         expWb;
   } vec_t;

   wb_t  sbQ[$];
   vec_t vecs[11];
   int   testsRun = 0;
   int   testsFailed = 0;

   function automatic wb_t mkWb(input logic [31:0] alu, input logic [31:0] ld,
                                input logic [31:0] pc4, input logic [31:0] inst,
                                input logic [4:0] rd, input logic [1:0] wbsel,
                                input logic rdwren, input logic vld);
      wb_t w;
      w.alu = alu; w.ld = ld; w.pc4 = pc4; w.inst = inst;
      w.rd = rd; w.wbsel = wbsel; w.rdwren = rdwren; w.vld = vld;
      return w;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      wb_t e;
      if (sbQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s.queue: got empty scoreboard, expected a pending entry", tag);
      end else begin
         e = sbQ.pop_front();
         checkVal({tag, ".WB_alu_data"}, wbAlu, e.alu);
         checkVal({tag, ".WB_ld_data"},  wbLd,  e.ld);
         checkVal({tag, ".WB_pc_four"},  wbPc4, e.pc4);
         checkVal({tag, ".WB_inst"},     wbInst, e.inst);
         checkVal({tag, ".WB_rd_addr"},  {27'h0, wbRd}, {27'h0, e.rd});
         checkVal({tag, ".WB_wb_sel"},   {30'h0, wbSel}, {30'h0, e.wbsel});
         checkVal({tag, ".WB_rd_wren"},  {31'h0, wbRdWren}, {31'h0, e.rdwren});
         checkVal({tag, ".WB_insn_vld"}, {31'h0, wbVld}, {31'h0, e.vld});
      end
   endtask

   task automatic driveMem(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] wbsel, input logic rdwren, input logic wren,
                           input logic rden, input logic vld);
      memAlu = alu; memRs2 = rs2; memPc = pc; memInst = inst; memRd = rd; memF3 = f3;
      memWbSel = wbsel; memRdWren = rdwren; memWren = wren; memRden = rden; memVld = vld;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      driveMem(v.alu, v.rs2, v.pc, v.inst, v.rd, v.f3, v.wbsel, v.rdwren, v.wren, v.rden, v.vld);
      dmemReady = v.ready;
      dmemRvalid = 1'b0;
      #1;
      checkVal({tag, ".req"},      {31'h0, dmemReq},     {31'h0, v.expReq});
      checkVal({tag, ".stall"},    {31'h0, memStall},    32'h0);
      checkVal({tag, ".misalign"}, {31'h0, misalignOut}, {31'h0, v.expMis});
      checkVal({tag, ".err"},      {31'h0, dmemErr},     32'h0);
      if (v.expReq) begin
         checkVal({tag, ".we"},    {31'h0, dmemWe},   {31'h0, v.expWe});
         checkVal({tag, ".addr"},  dmemAddr,          v.expAddr);
         checkVal({tag, ".wdata"}, dmemWdata,         v.expWdata);
         checkVal({tag, ".bmask"}, {28'h0, dmemMask}, {28'h0, v.expMask});
      end
      sbQ.push_back(v.expWb);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Ready arrives readyDly cycles after issue, rvalid rvalidDly cycles after that.
   task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input int readyDly, input int rvalidDly,
                          input logic [31:0] rdata, input logic [31:0] expLd);
      int last;
      last = readyDly + rvalidDly;
      @(negedge clk);
      driveMem(addr, 32'h0, 32'h0000_0800, 32'h0000_2003, rd, f3, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
      sbQ.push_back(mkWb(addr, expLd, 32'h0000_0804, 32'h0000_2003, rd, 2'b10, 1'b1, 1'b1));
      for (int c = 0; c <= last; c++) begin
         if (c > 0) @(negedge clk);
         dmemReady  = (c == readyDly);
         dmemRvalid = (c == last);
         dmemRdata  = (c == last) ? rdata : 32'hDEAD_BEEF;
         #1;
         checkVal($sformatf("%s.stall%0d", tag, c), {31'h0, memStall}, {31'h0, c < last});
         if (c <= readyDly) begin
            checkVal($sformatf("%s.req%0d", tag, c), {31'h0, dmemReq}, 32'h1);
            checkVal($sformatf("%s.addr%0d", tag, c), dmemAddr, {addr[31:2], 2'b00});
            checkVal($sformatf("%s.we%0d", tag, c), {31'h0, dmemWe}, 32'h0);
         end
         @(posedge clk);
         #1;
         if (c < last) checkVal($sformatf("%s.bubble%0d", tag, c), {31'h0, wbVld}, 32'h0);
         else checkOutput(tag);
      end
      @(negedge clk);
      dmemReady = 1'b0;
      dmemRvalid = 1'b0;
      driveMem(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0]  = '{32'h0000_1234, 32'h0, 32'h0000_0040, 32'h1234_0293, 5'd5, 3'b000, 2'b01,
                   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
                   mkWb(32'h1234, 32'h0, 32'h44, 32'h1234_0293, 5'd5, 2'b01, 1'b1, 1'b1)};
      vecs[1]  = '{32'h0000_0055, 32'h0, 32'hFFFF_FFFC, 32'h0550_0013, 5'd0, 3'b000, 2'b01,
                   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
                   mkWb(32'h55, 32'h0, 32'h0, 32'h0550_0013, 5'd0, 2'b01, 1'b0, 1'b1)};
      vecs[2]  = '{32'h0000_0103, 32'h0000_00AB, 32'h0000_0100, 32'h00B1_81A3, 5'd0, 3'b000, 2'b00,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'hABAB_ABAB, 4'b1000, 1'b0,
                   mkWb(32'h103, 32'h0, 32'h104, 32'h00B1_81A3, 5'd0, 2'b00, 1'b0, 1'b1)};
      vecs[3]  = '{32'h0000_0202, 32'h1234_CDEF, 32'h0000_0104, 32'h00B1_91A3, 5'd0, 3'b001, 2'b00,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'hCDEF_CDEF, 4'b1100, 1'b0,
                   mkWb(32'h202, 32'h0, 32'h108, 32'h00B1_91A3, 5'd0, 2'b00, 1'b0, 1'b1)};
      vecs[4]  = '{32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_0108, 32'h00B1_A1A3, 5'd0, 3'b010, 2'b00,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b1111, 1'b0,
                   mkWb(32'h300, 32'h0, 32'h10C, 32'h00B1_A1A3, 5'd0, 2'b00, 1'b0, 1'b1)};
      vecs[5]  = '{32'h0000_0101, 32'h1234_5678, 32'h0000_010C, 32'h00B1_80A3, 5'd0, 3'b000, 2'b00,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h7878_7878, 4'b0010, 1'b0,
                   mkWb(32'h101, 32'h0, 32'h110, 32'h00B1_80A3, 5'd0, 2'b00, 1'b0, 1'b1)};
      vecs[6]  = '{32'h0000_0101, 32'h0, 32'h0000_0110, 32'h0000_A383, 5'd7, 3'b010, 2'b10,
                   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1,
                   mkWb(32'h101, 32'h0, 32'h114, 32'h0000_A383, 5'd7, 2'b10, 1'b0, 1'b1)};
      vecs[7]  = '{32'h0000_0203, 32'h0000_1111, 32'h0000_0114, 32'h00B1_91A3, 5'd0, 3'b001, 2'b00,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1,
                   mkWb(32'h203, 32'h0, 32'h118, 32'h00B1_91A3, 5'd0, 2'b00, 1'b0, 1'b1)};
      vecs[8]  = '{32'h0000_0200, 32'h0, 32'h0000_0118, 32'h0000_A183, 5'd3, 3'b010, 2'b10,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
                   mkWb(32'h200, 32'h0, 32'h11C, 32'h0000_A183, 5'd3, 2'b10, 1'b0, 1'b0)};
      vecs[9]  = '{32'h0000_0400, 32'hCAFE_F00D, 32'h0000_011C, 32'h00B1_A023, 5'd0, 3'b010, 2'b00,
                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'hCAFE_F00D, 4'b1111, 1'b0,
                   mkWb(32'h400, 32'h0, 32'h120, 32'h00B1_A023, 5'd0, 2'b00, 1'b0, 1'b1)};
      vecs[10] = '{32'h0000_0105, 32'h0, 32'h0000_0120, 32'h0000_9403, 5'd8, 3'b001, 2'b10,
                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1,
                   mkWb(32'h105, 32'h0, 32'h124, 32'h0000_9403, 5'd8, 2'b10, 1'b0, 1'b1)};

      // Reset with an aligned load presented: handshake outputs must stay quiet.
      rstN = 1'b0;
      dmemReady = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'h0;
      driveMem(32'h0, 32'h0, 32'h0, 32'h0000_2003, 5'd1, 3'b010, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkVal("rst.req",   {31'h0, dmemReq},  32'h0);
      checkVal("rst.stall", {31'h0, memStall}, 32'h0);
      checkVal("rst.WB_insn_vld", {31'h0, wbVld}, 32'h0);
      checkVal("rst.WB_inst", wbInst, 32'h0);
      checkVal("rst.WB_pc_four", wbPc4, 32'h0);
      @(negedge clk);
      driveMem(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rstN = 1'b1;

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

      runLoad("lh",   3'b001, 32'h0000_0102, 5'd9,  2, 3, 32'h8001_0000, 32'hFFFF_8001);
      runLoad("lb",   3'b000, 32'h0000_0101, 5'd10, 0, 1, 32'h0000_8000, 32'hFFFF_FF80);
      runLoad("lbu",  3'b100, 32'h0000_0103, 5'd11, 1, 1, 32'hF100_0000, 32'h0000_00F1);
      runLoad("lhu",  3'b101, 32'h0000_0102, 5'd12, 0, 2, 32'h8001_0000, 32'h0000_8001);
      runLoad("lw",   3'b010, 32'h0000_0104, 5'd13, 0, 1, 32'h1234_5678, 32'h1234_5678);
      runLoad("f011", 3'b011, 32'h0000_0100, 5'd14, 0, 1, 32'hFFFF_FFFF, 32'h0);

      // Watchdog: ready never comes; abort after WAIT_LIMIT=4 cycles spent in REQ.
      @(negedge clk);
      driveMem(32'h0000_0100, 32'h0, 32'h0000_0900, 32'h0000_4203, 5'd4, 3'b100, 2'b10,
               1'b1, 1'b0, 1'b1, 1'b1);
      dmemReady = 1'b0;
      sbQ.push_back(mkWb(32'h100, 32'h0, 32'h904, 32'h0000_4203, 5'd4, 2'b10, 1'b0, 1'b1));
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         checkVal($sformatf("wdog.err%0d", c),   {31'h0, dmemErr},  {31'h0, c == 5});
         checkVal($sformatf("wdog.stall%0d", c), {31'h0, memStall}, {31'h0, c < 5});
         @(posedge clk);
         #1;
         if (c < 5) checkVal($sformatf("wdog.bubble%0d", c), {31'h0, wbVld}, 32'h0);
         else checkOutput("wdog");
      end
      applyStimulus(vecs[0], 0);

      // Reset while waiting in RESP, then a stray rvalid must be ignored.
      @(negedge clk);
      driveMem(32'h0000_0100, 32'h0, 32'h0000_0A00, 32'h0000_2303, 5'd6, 3'b010, 2'b10,
               1'b1, 1'b0, 1'b1, 1'b1);
      dmemReady = 1'b1;
      #1;
      checkVal("rresp.stall", {31'h0, memStall}, 32'h1);
      @(negedge clk);
      dmemReady = 1'b0;
      rstN = 1'b0;
      #1;
      checkVal("rresp.req",   {31'h0, dmemReq},  32'h0);
      checkVal("rresp.stall_in_rst", {31'h0, memStall}, 32'h0);
      @(posedge clk);
      #1;
      checkVal("rresp.WB_alu_data", wbAlu, 32'h0);
      checkVal("rresp.WB_rd_wren", {31'h0, wbRdWren}, 32'h0);
      checkVal("rresp.WB_insn_vld", {31'h0, wbVld}, 32'h0);
      @(negedge clk);
      rstN = 1'b1;
      driveMem(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      dmemRvalid = 1'b1;
      dmemRdata  = 32'h1234_5678;
      #1;
      checkVal("rresp.idle_req",   {31'h0, dmemReq},  32'h0);
      checkVal("rresp.idle_stall", {31'h0, memStall}, 32'h0);
      sbQ.push_back(mkWb(32'h0, 32'h0, 32'h4, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      checkOutput("rresp.stray");
      dmemRvalid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
